dmem_mmio_responder: RTL and testbench

- Target-side responder for the core's data-memory port (MemWrite/address/write-data out, read-data in). Sits between the pipelined core and the data RAM.
- Decodes each M-stage access to RAM, the MMIO register block or unmapped space.
- Returns read data combinationally in the same cycle, because the core expects asynchronous-read memory.
- MMIO block contains GPIO, a cycle counter and an 8-bit transmit FIFO drained by an external valid/ready consumer.

---
 rtl/dmem_mmio_responder_if.sv | 22 ++
 rtl/dmem_mmio_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_if.sv
// Core data-memory port: M-stage write enable, byte address and store data out of the core,
// combinational load data back into it.
interface dmem_mmio_responder_if;
  logic        MemWriteM_i;
  logic [31:0] DataAdrM_i;
  logic [31:0] WriteDataM_i;
  logic [31:0] ReadDataM_o;

  modport master (
    output MemWriteM_i,
    output DataAdrM_i,
    output WriteDataM_i,
    input  ReadDataM_o
  );

  modport slave (
    input  MemWriteM_i,
    input  DataAdrM_i,
    input  WriteDataM_i,
    output ReadDataM_o
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: decodes RAM / MMIO / unmapped and returns load data combinationally.
// The timer compare register and irq_o exist only when DMEM_MMIO_TIMER_IRQ_EN is defined.
module dmem_mmio_responder #(
  parameter int unsigned RAM_AW     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GPIO_W     = 16,
  parameter logic [31:0] IO_BASE    = 32'h0000_2000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dmem_mmio_responder_if.slave  bus,
  output logic                  ram_we_o,
  input  logic [31:0]           ram_spo_i,
  output logic [GPIO_W-1:0]     gpio_o,
  input  logic [GPIO_W-1:0]     gpio_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
`ifdef DMEM_MMIO_TIMER_IRQ_EN
  output logic                  irq_o,
`endif
  input  logic                  tx_ready_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RamByteAw = RAM_AW + 2;

  // Decode
  logic       w_ram_sel, w_io_sel, w_io_we, w_unm_we;
  logic [2:0] w_off;
  logic       w_wr_gpio, w_wr_cycle, w_wr_status, w_push;

  assign w_ram_sel   = (bus.DataAdrM_i >> RamByteAw) == 32'd0;
  assign w_io_sel    = !w_ram_sel && (bus.DataAdrM_i[31:5] == IO_BASE[31:5]);
  assign w_off       = bus.DataAdrM_i[4:2];
  assign w_io_we     = bus.MemWriteM_i & w_io_sel;
  assign w_unm_we    = bus.MemWriteM_i & !w_ram_sel & !w_io_sel;
  assign w_wr_gpio   = w_io_we & (w_off == 3'd0);
  assign w_wr_cycle  = w_io_we & (w_off == 3'd2);
  assign w_push      = w_io_we & (w_off == 3'd3);
  assign w_wr_status = w_io_we & (w_off == 3'd4);
  assign ram_we_o    = bus.MemWriteM_i & w_ram_sel;

  // State
  logic [GPIO_W-1:0] r_gpio, r_gpio_s1, r_gpio_s2;
  logic [31:0]       r_cycle;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count, w_count_d;
  logic              r_ovf, r_unm;
  logic              w_irq_pend;

  logic w_empty, w_full, w_pop, w_push_acc, w_ovf_set;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntW'(FIFO_DEPTH));
  assign w_pop      = !w_empty & tx_ready_i;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign w_push_acc = w_push & (!w_full | w_pop);
  assign w_ovf_set  = w_push & w_full & !w_pop;

  always_comb begin
    w_count_d = r_count;
    if (w_push_acc && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (!w_push_acc && w_pop) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_gpio    <= '0;
      r_gpio_s1 <= '0;
      r_gpio_s2 <= '0;
      r_cycle   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_unm     <= 1'b0;
    end else begin
      if (w_wr_gpio) r_gpio <= bus.WriteDataM_i[GPIO_W-1:0];
      r_gpio_s1 <= gpio_i;
      r_gpio_s2 <= r_gpio_s1;
      r_cycle   <= w_wr_cycle ? 32'd0 : r_cycle + 32'd1;
      if (w_push_acc) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      r_count   <= w_count_d;
      r_ovf     <= w_ovf_set | (r_ovf & !(w_wr_status & bus.WriteDataM_i[2]));
      r_unm     <= w_unm_we | (r_unm & !(w_wr_status & bus.WriteDataM_i[3]));
    end
  end

  // Storage is deliberately not reset; only pointers define validity.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_push_acc) r_mem[r_wptr] <= bus.WriteDataM_i[7:0];
  end

`ifdef DMEM_MMIO_TIMER_IRQ_EN
  logic [31:0] r_cmp;
  logic        r_irq;
  logic        w_wr_cmp;

  assign w_wr_cmp = w_io_we & (w_off == 3'd5);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cmp <= 32'hFFFF_FFFF;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_cmp) r_cmp <= bus.WriteDataM_i;
      r_irq <= (r_cycle == r_cmp) | (r_irq & !(w_wr_status & bus.WriteDataM_i[4]));
    end
  end

  assign w_irq_pend = r_irq;
  assign irq_o      = r_irq;
`else
  assign w_irq_pend = 1'b0;
`endif

  // Read path
  logic [31:0] w_status, w_io_rdata;

  assign w_status = {16'h0, 8'(r_count), 3'b000, w_irq_pend, r_unm, r_ovf, w_full, w_empty};

  always_comb begin
    w_io_rdata = 32'd0;
    case (w_off)
      3'd0:    w_io_rdata = 32'(r_gpio);
      3'd1:    w_io_rdata = 32'(r_gpio_s2);
      3'd2:    w_io_rdata = r_cycle;
      3'd4:    w_io_rdata = w_status;
`ifdef DMEM_MMIO_TIMER_IRQ_EN
      3'd5:    w_io_rdata = r_cmp;
`endif
      default: w_io_rdata = 32'd0;
    endcase
  end

  assign bus.ReadDataM_o = w_ram_sel ? ram_spo_i : (w_io_sel ? w_io_rdata : 32'd0);

  assign gpio_o     = r_gpio;
  assign tx_valid_o = !w_empty;
  assign tx_data_o  = r_mem[r_rptr];

  // Byte-lane bits and unused store-data bits.
  logic w_unused;
  assign w_unused = &{1'b0, bus.DataAdrM_i[1:0], bus.WriteDataM_i};

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: vector table, directed corner sequences, randomized run
// against a queue-based reference model. Honors DMEM_MMIO_TIMER_IRQ_EN.
module tb_dmem_mmio_responder;

  localparam int unsigned Depth = 8;
  localparam logic [31:0] RamEnd = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_we;
  logic [31:0] ram_spo;
  logic [15:0] gpio_o_w, gpio_i_w;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        irq;

  dmem_mmio_responder_if bus_if ();

  dmem_mmio_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus_if),
    .ram_we_o   (ram_we),
    .ram_spo_i  (ram_spo),
    .gpio_o     (gpio_o_w),
    .gpio_i     (gpio_i_w),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
`ifdef DMEM_MMIO_TIMER_IRQ_EN
    .irq_o      (irq),
`endif
    .tx_ready_i (tx_ready)
  );

`ifndef DMEM_MMIO_TIMER_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] spo;
    logic [31:0] exp_rd;
    logic        exp_we;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bus_if.MemWriteM_i  = we;
    bus_if.DataAdrM_i   = adr;
    bus_if.WriteDataM_i = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0000_0000, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
  endtask

  task automatic add_vec(input string n, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] spo,
                         input logic [31:0] exp_rd, input logic exp_we);
    vec_t v;
    v.name = n; v.we = we; v.adr = adr; v.wd = wd; v.spo = spo;
    v.exp_rd = exp_rd; v.exp_we = exp_we;
    vecs.push_back(v);
  endtask

  // Reference model state (post-edge view)
  logic [15:0] m_gpio, m_s1, m_s2;
  logic [31:0] m_cycle, m_cmp;
  logic        m_ovf, m_unm, m_irq;
  logic [7:0]  m_q[$];

  task automatic model_reset();
    m_gpio = '0; m_s1 = '0; m_s2 = '0; m_cycle = '0; m_cmp = 32'hFFFF_FFFF;
    m_ovf = 1'b0; m_unm = 1'b0; m_irq = 1'b0;
    m_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] adr, input logic [31:0] spo);
    logic [31:0] st;
    int          sz;
    sz = m_q.size();
    st = {16'h0, 8'(sz), 3'b000, m_irq, m_unm, m_ovf, (sz == Depth), (sz == 0)};
    if (adr < RamEnd) return spo;
    if ((adr & 32'hFFFF_FFE0) != 32'h0000_2000) return 32'h0;
    case (adr[4:2])
      3'd0: return {16'h0, m_gpio};
      3'd1: return {16'h0, m_s2};
      3'd2: return m_cycle;
      3'd4: return st;
`ifdef DMEM_MMIO_TIMER_IRQ_EN
      3'd5: return m_cmp;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic we, input logic [31:0] adr,
                            input logic [31:0] wd, input logic rdy, input logic [15:0] gin);
    logic io, unm, pop, push;
    int   off;
    if (!r) begin
      model_reset();
      return;
    end
    io   = (adr & 32'hFFFF_FFE0) == 32'h0000_2000;
    unm  = we && adr >= RamEnd && !io;
    off  = int'(adr[4:2]);
    pop  = (m_q.size() != 0) && rdy;
    push = we && io && off == 3;
`ifdef DMEM_MMIO_TIMER_IRQ_EN
    m_irq = (m_cycle == m_cmp) || (m_irq && !(we && io && off == 4 && wd[4]));
    if (we && io && off == 5) m_cmp = wd;
`endif
    if (push && !pop && m_q.size() == Depth) m_ovf = 1'b1;
    else if (we && io && off == 4 && wd[2]) m_ovf = 1'b0;
    if (unm) m_unm = 1'b1;
    else if (we && io && off == 4 && wd[3]) m_unm = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < Depth) m_q.push_back(wd[7:0]);
    m_cycle = (we && io && off == 2) ? 32'h0 : m_cycle + 32'd1;
    if (we && io && off == 0) m_gpio = wd[15:0];
    m_s2 = m_s1;
    m_s1 = gin;
  endtask

  initial begin
    logic [7:0] exp_b;
    rst = 1'b0; tx_ready = 1'b0; ram_spo = '0; gpio_i_w = '0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_gpio_o", {16'h0, gpio_o_w}, 32'h0);
    drive(1'b0, 32'h0000_2010, 32'h0);
    #1 check("rst_status", bus_if.ReadDataM_o, 32'h0000_0001);
    do_reset();

    // Table of single-cycle accesses; expectations follow the address map.
    add_vec("gpio_wr",      1, 32'h0000_2000, 32'h1234_ABCD, 32'h0,         32'h0,         0);
    add_vec("gpio_rd",      0, 32'h0000_2000, 32'h0,         32'h0,         32'h0000_ABCD, 0);
    add_vec("ram_wr",       1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0BAD_F00D, 1);
    add_vec("ram_rd",       0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    add_vec("ram_top_wr",   1, 32'h0000_03FC, 32'h0,         32'h0000_0055, 32'h0000_0055, 1);
    add_vec("ram_end_rd",   0, 32'h0000_0400, 32'h0,         32'h0000_0077, 32'h0,         0);
    add_vec("status_a",     0, 32'h0000_2010, 32'h0,         32'h0,         32'h0000_0001, 0);
    add_vec("unm_wr",       1, 32'h0000_4000, 32'h1,         32'h0000_0099, 32'h0,         0);
    add_vec("status_unm",   0, 32'h0000_2013, 32'h0,         32'h0,         32'h0000_0009, 0);
    add_vec("status_ro_wr", 1, 32'h0000_2010, 32'h3,         32'h0,         32'h0000_0009, 0);
    add_vec("status_ro",    0, 32'h0000_2010, 32'h0,         32'h0,         32'h0000_0009, 0);
    add_vec("status_w1c",   1, 32'h0000_2010, 32'h8,         32'h0,         32'h0000_0009, 0);
    add_vec("status_clr",   0, 32'h0000_2010, 32'h0,         32'h0,         32'h0000_0001, 0);
    add_vec("txdata_rd",    0, 32'h0000_200C, 32'h0,         32'h0,         32'h0,         0);
    add_vec("off18_rd",     0, 32'h0000_2018, 32'h0,         32'h0,         32'h0,         0);
`ifdef DMEM_MMIO_TIMER_IRQ_EN
    add_vec("cmp_rd",       0, 32'h0000_2014, 32'h0,         32'h0,         32'hFFFF_FFFF, 0);
`else
    add_vec("cmp_rd",       0, 32'h0000_2014, 32'h0,         32'h0,         32'h0,         0);
`endif
    add_vec("past_io_wr",   1, 32'h0000_2020, 32'h0,         32'h0,         32'h0,         0);
    add_vec("status_unm2",  0, 32'h0000_2010, 32'h0,         32'h0,         32'h0000_0009, 0);
    add_vec("gpio_in_rd",   0, 32'h0000_2004, 32'h0,         32'h0,         32'h0,         0);
    add_vec("gpio_keep",    0, 32'h0000_2000, 32'h0,         32'h0,         32'h0000_ABCD, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].adr, vecs[i].wd);
      ram_spo = vecs[i].spo;
      #1;
      check({vecs[i].name, "_rd"}, bus_if.ReadDataM_o, vecs[i].exp_rd);
      check({vecs[i].name, "_we"}, {31'h0, ram_we}, {31'h0, vecs[i].exp_we});
      tick();
    end
    check("gpio_o_after_wr", {16'h0, gpio_o_w}, 32'h0000_ABCD);

    // GPIO input synchronizer: two edges of latency.
    do_reset();
    gpio_i_w = 16'h5A5A;
    drive(1'b0, 32'h0000_2004, 32'h0);
    tick();
    check("gpio_sync_1", bus_if.ReadDataM_o, 32'h0);
    tick();
    check("gpio_sync_2", bus_if.ReadDataM_o, 32'h0000_5A5A);
    gpio_i_w = '0;

    // Nine pushes into an 8-deep FIFO with the consumer stalled.
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 32'h0000_200C, 32'(i));
      tick();
    end
    drive(1'b0, 32'h0000_2010, 32'h0);
    #1;
    check("fifo_full_status", bus_if.ReadDataM_o, 32'h0000_0806);
    check("fifo_head", {24'h0, tx_data}, 32'h01);
    tx_ready = 1'b1;
    idle();
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("drain_valid", {31'h0, tx_valid}, 32'h1);
      check("drain_data", {24'h0, tx_data}, 32'(i));
      tick();
    end
    check("drain_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    drive(1'b0, 32'h0000_2010, 32'h0);
    #1 check("ovf_sticky", bus_if.ReadDataM_o, 32'h0000_0005);
    drive(1'b1, 32'h0000_2010, 32'h4);
    tick();
    drive(1'b0, 32'h0000_2010, 32'h0);
    #1 check("ovf_cleared", bus_if.ReadDataM_o, 32'h0000_0001);

    // Full FIFO: push and pop on the same edge.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h0000_200C, 32'h10 + 32'(i));
      tick();
    end
    tx_ready = 1'b1;
    drive(1'b1, 32'h0000_200C, 32'hAA);
    tick();
    tx_ready = 1'b0;
    drive(1'b0, 32'h0000_2010, 32'h0);
    #1 check("full_pushpop_status", bus_if.ReadDataM_o, 32'h0000_0802);
    tx_ready = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'hAA : 8'h11 + 8'(i);
      #1 check("pushpop_order", {24'h0, tx_data}, {24'h0, exp_b});
      tick();
    end
    check("pushpop_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // CYCLE write clears; five edges later it reads 5.
    drive(1'b1, 32'h0000_2008, 32'h1234_5678);
    tick();
    idle();
    repeat (5) tick();
    drive(1'b0, 32'h0000_2008, 32'h0);
    #1 check("cycle_5", bus_if.ReadDataM_o, 32'd5);

`ifdef DMEM_MMIO_TIMER_IRQ_EN
    // Clear CYCLE, then CMP=20: irq sets on the edge where CYCLE==20.
    drive(1'b1, 32'h0000_2008, 32'h0);
    tick();
    drive(1'b1, 32'h0000_2014, 32'd20);
    tick();
    drive(1'b0, 32'h0000_2014, 32'h0);
    #1 check("cmp_readback", bus_if.ReadDataM_o, 32'd20);
    idle();
    for (int k = 2; k <= 22; k++) begin
      tick();
      check("irq_timing", {31'h0, irq}, {31'h0, (k >= 21)});
    end
    drive(1'b0, 32'h0000_2010, 32'h0);
    #1 check("irq_status", bus_if.ReadDataM_o, 32'h0000_0011);
`endif

    // Reset mid-count with a byte queued and a push in the reset cycle.
    drive(1'b1, 32'h0000_2000, 32'h0000_FFFF);
    tick();
    drive(1'b1, 32'h0000_200C, 32'h5C);
    tick();
    check("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
    rst = 1'b0;
    drive(1'b1, 32'h0000_200C, 32'h66);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0000_2010, 32'h0);
    #1;
    check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("mid_rst_gpio", {16'h0, gpio_o_w}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check("mid_rst_status", bus_if.ReadDataM_o, 32'h0000_0001);
    drive(1'b0, 32'h0000_2008, 32'h0);
    #1 check("mid_rst_cycle", bus_if.ReadDataM_o, 32'h0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      logic        r_in, we, rdy;
      logic [31:0] adr, wd, spo;
      logic [15:0] gin;
      int          sel;
      sel = $urandom_range(0, 11);
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if (sel <= 1)      adr = $urandom_range(0, 1023);
      else if (sel <= 4) begin adr = 32'h0000_200C; we = 1'b1; end
      else if (sel <= 8) adr = 32'h0000_2000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      else if (sel == 9) adr = $urandom | 32'h0001_0000;
      else               adr = 32'h0000_2010;
      if (adr[4:2] == 3'd5 && adr >= 32'h2000) wd = m_cycle + 32'($urandom_range(2, 30));
      spo  = $urandom;
      gin  = 16'($urandom);
      rdy  = 1'($urandom_range(0, 1));
      r_in = ($urandom_range(0, 63) != 0);
      rst = r_in; tx_ready = rdy; ram_spo = spo; gpio_i_w = gin;
      drive(we, adr, wd);
      #1;
      check("rnd_rd", bus_if.ReadDataM_o, model_read(adr, spo));
      check("rnd_we", {31'h0, ram_we}, {31'h0, we && adr < RamEnd});
      check("rnd_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
      if (m_q.size() != 0) check("rnd_data", {24'h0, tx_data}, {24'h0, m_q[0]});
      check("rnd_gpio", {16'h0, gpio_o_w}, {16'h0, m_gpio});
      check("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
      tick();
      model_step(r_in, we, adr, wd, rdy, gin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
